// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-requester packet arbiter.
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties)
// instead of the default round-robin tie break.
package arb_pkg;

  localparam int ARB_REQ_N = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // One-hot grant vector for a requester index
  function automatic logic [ARB_REQ_N-1:0] arb_onehot(input logic idx);
    arb_onehot      = '0;
    arb_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux_2to1.sv
// Single-bit 2:1 mux cell; the arbiter stacks WIDTH+1 of these for data and last.
// The select port keeps the cell's historical name (sel).
module mux_2to1 (
  input  logic d0_i,
  input  logic d1_i,
  input  logic sel,
  output logic y_o
);

  assign y_o = sel ? d1_i : d0_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Packet-locked arbiter sharing one valid/ready channel between two requesters.
// A grant is taken one cycle after a valid is seen in IDLE and is held until the
// beat carrying last is accepted, leaving one idle bubble between packets.
// Build option: ARB_FIXED_PRIO_EN -> requester 0 always wins a tie; when undefined
// the tie goes to the requester not served most recently.
module mux2_rr_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic [1:0]       grant
);

  arb_state_t           state_q, state_d;
  logic                 sel_q, sel_d;
  logic [ARB_REQ_N-1:0] grant_q, grant_d;
`ifndef ARB_FIXED_PRIO_EN
  logic                 last_srv_q, last_srv_d;
`endif

  logic [ARB_REQ_N-1:0] req_vld;
  logic                 pick;
  logic                 pkt_done;
  logic [WIDTH:0]       mux_a, mux_b, mux_y;

  assign req_vld = {in1_valid, in0_valid};

  // Winner when leaving IDLE: lone requester, otherwise tie-break rule
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    pick = ~in0_valid;
`else
    pick = (in0_valid & in1_valid) ? ~last_srv_q : in1_valid;
`endif
  end

  // Packet ends when the granted requester's last beat is taken downstream
  assign pkt_done = (|grant_q) & out_valid & out_ready & out_last;

  // Next-state: grab a requester from IDLE, release on end of packet
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
`ifndef ARB_FIXED_PRIO_EN
    last_srv_d = last_srv_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req_vld) begin
          state_d    = pick ? ARB_GNT1 : ARB_GNT0;
          sel_d      = pick;
          grant_d    = arb_onehot(pick);
`ifndef ARB_FIXED_PRIO_EN
          last_srv_d = pick;
`endif
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (pkt_done) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, select and grant registers; last_srv resets to 1 so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      sel_q      <= 1'b0;
      grant_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_srv_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
`ifndef ARB_FIXED_PRIO_EN
      last_srv_q <= last_srv_d;
`endif
    end
  end

  // Data path: bit WIDTH carries last, lower bits carry data
  assign mux_a = {in0_last, in0_data};
  assign mux_b = {in1_last, in1_data};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_mux
    mux_2to1 u_mux (
      .d0_i (mux_a[i]),
      .d1_i (mux_b[i]),
      .sel  (sel_q),
      .y_o  (mux_y[i])
    );
  end

  assign out_data  = mux_y[WIDTH-1:0];
  assign out_last  = mux_y[WIDTH];

  // Handshake gating: only the granted requester sees the channel
  assign out_valid = |(grant_q & req_vld);
  assign in0_ready = grant_q[0] & out_ready;
  assign in1_ready = grant_q[1] & out_ready;

  assign sel   = sel_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus a random run,
// each cycle compared against a small owner/last-served reference model.
module tb_mux2_rr_arbiter;

  localparam int W = 8;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in0_valid = 1'b0, in0_last = 1'b0, in1_valid = 1'b0, in1_last = 1'b0;
  logic [W-1:0] in0_data = '0, in1_data = '0;
  logic         out_ready = 1'b1;
  logic         in0_ready, in1_ready, out_valid, out_last, sel;
  logic [W-1:0] out_data;
  logic [1:0]   grant;

  mux2_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .grant(grant)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_pass = 0, cyc_n = 0;
  logic [W:0] q0[$], q1[$];          // pending beats {last,data} per requester
  logic       h0 = 1'b0, h1 = 1'b0;  // force valid low (mid-packet drop)
  logic [W:0] acc_d[$];              // accepted downstream beats
  int         acc_c[$];              // cycle each beat was accepted

  // Reference model: which requester owns the channel (-1 none), who was served last
  int   m_own  = -1;
  int   m_last = 1;
  logic m_sel  = 1'b0;

  function automatic int pick_next();
    if (in0_valid && in1_valid) return FIXED ? 0 : 1 - m_last;
    return in1_valid ? 1 : 0;
  endfunction
  function automatic logic e_valid();
    return (m_own == 0) ? in0_valid : (m_own == 1) ? in1_valid : 1'b0;
  endfunction
  function automatic logic e_last();
    return (m_own == 1) ? in1_last : in0_last;
  endfunction
  function automatic logic [W-1:0] e_data();
    return (m_own == 1) ? in1_data : in0_data;
  endfunction
  function automatic logic [1:0] e_grant();
    return (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
  endfunction
  function automatic logic e_rdy(input int r);
    return (m_own == r) && out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own <= -1; m_last <= 1; m_sel <= 1'b0;
    end else if (m_own < 0) begin
      if (in0_valid || in1_valid) begin
        m_own <= pick_next(); m_last <= pick_next(); m_sel <= (pick_next() == 1);
      end
    end else if (e_valid() && out_ready && e_last()) begin
      m_own <= -1;
    end
  end

  task automatic apply();
    in0_valid = (q0.size() != 0) && !h0;
    {in0_last, in0_data} = (q0.size() != 0) ? q0[0] : 9'($urandom);
    in1_valid = (q1.size() != 0) && !h1;
    {in1_last, in1_data} = (q1.size() != 0) ? q1[0] : 9'($urandom);
  endtask

  // Called mid-cycle: note handshakes, move to just after the next rising edge
  task automatic advance();
    logic hs0, hs1;
    hs0 = in0_valid && in0_ready;
    hs1 = in1_valid && in1_ready;
    if (out_valid && out_ready) begin
      acc_d.push_back({out_last, out_data});
      acc_c.push_back(cyc_n);
    end
    @(posedge clk); #1;
    cyc_n++;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    apply();
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; h0 = 1'b0; h1 = 1'b0;
    q0 = {9'h0AA}; q1 = {9'h0BB};
    apply();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++;
      if ({out_valid, grant, sel, in0_ready, in1_ready} !== 6'b0)
        $display("FAIL reset cyc %0d: got %b want 000000", k, {out_valid, grant, sel, in0_ready, in1_ready});
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_contention();
    logic [W:0] exp_b[8];
    int         exp_c[8] = '{1, 2, 4, 5, 7, 8, 10, 11};
    int         t0;
`ifdef ARB_FIXED_PRIO_EN
    exp_b = '{9'h010, 9'h111, 9'h012, 9'h113, 9'h020, 9'h121, 9'h022, 9'h123};
`else
    exp_b = '{9'h010, 9'h111, 9'h020, 9'h121, 9'h012, 9'h113, 9'h022, 9'h123};
`endif
    q0 = {9'h010, 9'h111, 9'h012, 9'h113};
    q1 = {9'h020, 9'h121, 9'h022, 9'h123};
    h0 = 1'b0; h1 = 1'b0; out_ready = 1'b1; acc_d = {}; acc_c = {};
    apply();
    rst = 1'b0;
    t0 = cyc_n;
    for (int k = 0; k < 30 && acc_d.size() < 8; k++) begin
      @(negedge clk);
      n_chk++;
      if ({grant, sel, out_valid, in0_ready, in1_ready} !== {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)})
        $display("FAIL contention ctl cyc %0d: got %b want %b", k, {grant, sel, out_valid, in0_ready, in1_ready},
                 {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)});
      else n_pass++;
      advance();
    end
    n_chk++;
    if (acc_d.size() != 8) $display("FAIL contention beats: got %0d want 8", acc_d.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < acc_d.size(); i++) begin
      n_chk++;
      if (acc_d[i] !== exp_b[i] || acc_c[i] - t0 != exp_c[i])
        $display("FAIL contention beat %0d: got %h@%0d want %h@%0d", i, acc_d[i], acc_c[i] - t0, exp_b[i], exp_c[i]);
      else n_pass++;
    end
  endtask

  task automatic test_solo();
    logic [W:0] exp_b[3] = '{9'h0A1, 9'h0A2, 9'h1A3};
    int         t0;
    q0 = {9'h0A1, 9'h0A2, 9'h1A3}; q1 = {}; acc_d = {}; acc_c = {};
    apply();
    t0 = cyc_n;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_chk++;
      if ({grant, sel, out_valid, in0_ready, in1_ready} !== {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)})
        $display("FAIL solo ctl cyc %0d: got %b want %b", k, {grant, sel, out_valid, in0_ready, in1_ready},
                 {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)});
      else n_pass++;
      if (k == 0 || k == 1 || k == 4) begin
        n_chk++;
        if (grant !== ((k == 1) ? 2'b01 : 2'b00))
          $display("FAIL solo grant cyc %0d: got %b want %b", k, grant, (k == 1) ? 2'b01 : 2'b00);
        else n_pass++;
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= acc_d.size() || acc_d[i] !== exp_b[i] || acc_c[i] - t0 != i + 1)
        $display("FAIL solo beat %0d: got %h want %h@%0d", i, (i < acc_d.size()) ? acc_d[i] : 9'h0, exp_b[i], i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp_b[4] = '{9'h030, 9'h031, 9'h132, 9'h140};
    int         exp_c[4] = '{1, 6, 7, 9};
    int         t0;
    q1 = {9'h030, 9'h031, 9'h132}; q0 = {}; acc_d = {}; acc_c = {};
    apply();
    t0 = cyc_n;
    for (int k = 0; k < 12; k++) begin
      out_ready = !(k >= 2 && k < 6);
      if (k == 2) begin q0.push_back(9'h140); apply(); end
      @(negedge clk);
      n_chk++;
      if ({grant, sel, out_valid, in0_ready, in1_ready} !== {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)})
        $display("FAIL backpressure ctl cyc %0d: got %b want %b", k, {grant, sel, out_valid, in0_ready, in1_ready},
                 {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)});
      else n_pass++;
      if (k >= 2 && k < 6) begin
        n_chk++;
        if ({out_data, in1_ready, in0_ready, grant} !== {8'h31, 1'b0, 1'b0, 2'b10})
          $display("FAIL backpressure hold cyc %0d: got %h/%b%b/%b want 31/00/10", k, out_data, in1_ready, in0_ready, grant);
        else n_pass++;
      end
      advance();
    end
    out_ready = 1'b1;
    n_chk++;
    if (acc_d.size() != 4) $display("FAIL backpressure beats: got %0d want 4", acc_d.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < acc_d.size(); i++) begin
      n_chk++;
      if (acc_d[i] !== exp_b[i] || acc_c[i] - t0 != exp_c[i])
        $display("FAIL backpressure beat %0d: got %h@%0d want %h@%0d", i, acc_d[i], acc_c[i] - t0, exp_b[i], exp_c[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lock();
    logic [W:0] exp_b[5] = '{9'h050, 9'h051, 9'h052, 9'h153, 9'h160};
    int         exp_c[5] = '{1, 2, 6, 7, 9};
    int         t0;
    q1 = {9'h050, 9'h051, 9'h052, 9'h153}; q0 = {}; acc_d = {}; acc_c = {}; out_ready = 1'b1;
    apply();
    t0 = cyc_n;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) q0.push_back(9'h160);
      h1 = (k >= 3 && k < 6);
      apply();
      @(negedge clk);
      n_chk++;
      if ({grant, sel, out_valid, in0_ready, in1_ready} !== {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)})
        $display("FAIL lock ctl cyc %0d: got %b want %b", k, {grant, sel, out_valid, in0_ready, in1_ready},
                 {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)});
      else n_pass++;
      if (k >= 3 && k < 6) begin
        n_chk++;
        if ({grant, out_valid, in0_ready} !== 4'b1000)
          $display("FAIL lock hold cyc %0d: got %b want 1000", k, {grant, out_valid, in0_ready});
        else n_pass++;
      end
      advance();
    end
    h1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (i >= acc_d.size() || acc_d[i] !== exp_b[i] || acc_c[i] - t0 != exp_c[i])
        $display("FAIL lock beat %0d: got %h want %h@%0d", i, (i < acc_d.size()) ? acc_d[i] : 9'h0, exp_b[i], exp_c[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int pushed = 0, taken;
    acc_d = {}; acc_c = {};
    for (int k = 0; k < 800; k++) begin
      if (k < 600) begin
        out_ready = ($urandom_range(0, 3) != 0);
        h0 = ($urandom_range(0, 4) == 0);
        h1 = ($urandom_range(0, 4) == 0);
        if (q0.size() < 3 && $urandom_range(0, 3) == 0) begin
          int n = $urandom_range(1, 4);
          for (int b = 0; b < n; b++) q0.push_back({b == n - 1, 8'($urandom)});
          pushed += n;
        end
        if (q1.size() < 3 && $urandom_range(0, 3) == 0) begin
          int n = $urandom_range(1, 4);
          for (int b = 0; b < n; b++) q1.push_back({b == n - 1, 8'($urandom)});
          pushed += n;
        end
      end else begin
        out_ready = 1'b1; h0 = 1'b0; h1 = 1'b0;
      end
      apply();
      @(negedge clk);
      n_chk++;
      if ({grant, sel, out_valid, in0_ready, in1_ready} !== {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)})
        $display("FAIL random ctl cyc %0d: got %b want %b", k, {grant, sel, out_valid, in0_ready, in1_ready},
                 {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)});
      else n_pass++;
      if (e_valid()) begin
        n_chk++;
        if ({out_last, out_data} !== {e_last(), e_data()})
          $display("FAIL random data cyc %0d: got %h want %h", k, {out_last, out_data}, {e_last(), e_data()});
        else n_pass++;
      end
      advance();
    end
    taken = acc_d.size();
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0 || taken != pushed)
      $display("FAIL random drain: got %0d beats left %0d/%0d want %0d beats none left", taken, q0.size(), q1.size(), pushed);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    q1 = {9'h070, 9'h071, 9'h072, 9'h173}; q0 = {}; out_ready = 1'b1; h0 = 1'b0; h1 = 1'b0;
    apply();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if ({grant, sel, out_valid, in0_ready, in1_ready} !== {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)})
        $display("FAIL resetmid ctl cyc %0d: got %b want %b", k, {grant, sel, out_valid, in0_ready, in1_ready},
                 {e_grant(), m_sel, e_valid(), e_rdy(0), e_rdy(1)});
      else n_pass++;
      if (k < 2) advance();
    end
    n_chk++;
    if ({out_valid, out_data} !== {1'b1, 8'h71})
      $display("FAIL resetmid beat2: got %b/%h want 1/71", out_valid, out_data);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({grant, out_valid, in1_ready, in0_ready, sel} !== 6'b0)
      $display("FAIL resetmid async: got %b want 000000", {grant, out_valid, in1_ready, in0_ready, sel});
    else n_pass++;
    q1 = {}; apply();
    advance();
    @(negedge clk);
    n_chk++;
    if ({grant, out_valid, sel} !== 4'b0)
      $display("FAIL resetmid idle: got %b want 0000", {grant, out_valid, sel});
    else n_pass++;
    advance();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_solo();
    test_backpressure();
    test_lock();
    test_random();
    test_reset_mid();
    test_contention();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
